// File: rtl/sync_debounce_if.sv
// sync_debounce_if
//   Groups the data-path signals of the input conditioner.
//   d    : raw asynchronous level into the conditioner
//   q    : debounced, registered level
//   rise : one-cycle pulse when q goes 1
//   fall : one-cycle pulse when q goes 0
//   busy : candidate transition being qualified
//   master : the side that owns the raw level and consumes the clean outputs
//   slave  : the conditioner itself
interface sync_debounce_if;
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output d,
        input  q,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  d,
        output q,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce
//   Conditions a raw asynchronous level into a clean synchronous level with
//   one-cycle edge pulses. A SYNC_STAGES-deep flop chain removes metastability,
//   then a four-state FSM requires DEBOUNCE_CYCLES consecutive agreeing samples
//   before the output level changes.
//
//   Ports
//     clock : rising-edge clock, the only clock of the block
//     clear : synchronous active-high reset, priority over everything
//     port  : sync_debounce_if.slave (d in; q, rise, fall, busy out)
//
//   Parameters
//     SYNC_STAGES     : synchronizer depth, 2..4
//     DEBOUNCE_CYCLES : consecutive agreeing samples to change q, 1..255
//     CNT_W           : counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   LOW        | q = 0, synchronized input agrees with q
//   WAIT_HIGH  | q = 0, counting consecutive 1 samples
//   HIGH       | q = 1, synchronized input agrees with q
//   WAIT_LOW   | q = 1, counting consecutive 0 samples
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic           clock,
    input  logic           clear,
    sync_debounce_if.slave port
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    // cnt holds (samples seen - 1); reaching LAST means this sample is the Nth.
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam bit               SINGLE = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] s_q;
    logic                   ds;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic q_q;
    logic q_d;
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;
    logic busy_q;
    logic busy_d;

    // Synchronizer chain: s_q[0] captures the raw level, the last stage is safe.
    always_ff @(posedge clock) begin
        if (clear) begin
            s_q <= '0;
        end else begin
            s_q <= {s_q[SYNC_STAGES-2:0], port.d};
        end
    end

    assign ds = s_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            ST_LOW: begin
                if (ds) begin
                    if (SINGLE) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                        cnt_d   = ONE;
                    end
                end
            end

            ST_WAIT_HIGH: begin
                // A disagreeing sample always wins, even on the would-be final edge.
                if (!ds) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            ST_HIGH: begin
                if (!ds) begin
                    if (SINGLE) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = ONE;
                    end
                end
            end

            ST_WAIT_LOW: begin
                if (ds) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state and registered alongside it.
        q_d    = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
        busy_d = (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
    end

    assign port.q    = q_q;
    assign port.rise = rise_q;
    assign port.fall = fall_q;
    assign port.busy = busy_q;

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic clear_a;
    logic clear_b;

    sync_debounce_if if_a ();
    sync_debounce_if if_b ();

    sync_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut_a (
        .clock(clock),
        .clear(clear_a),
        .port (if_a)
    );

    sync_debounce #(
        .SYNC_STAGES    (3),
        .DEBOUNCE_CYCLES(1),
        .CNT_W          (8)
    ) dut_b (
        .clock(clock),
        .clear(clear_b),
        .port (if_b)
    );

    // Expected outputs packed as {q, rise, fall, busy}, valid after the edge.
    typedef struct {
        bit         dut;
        bit         clr;
        bit         d;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb_exp[$];
    string      sb_name[$];

    int checks = 0;
    int errors = 0;

    function automatic void add(input bit dut, input string name, input bit clr,
                                input bit d, input logic [3:0] exp);
        vec_t v;
        v.dut  = dut;
        v.clr  = clr;
        v.d    = d;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [3:0] got;
        logic [3:0] exp;
        string      nm;
        @(negedge clock);
        if (v.dut) begin
            clear_b = v.clr;
            if_b.d  = v.d;
        end else begin
            clear_a = v.clr;
            if_a.d  = v.d;
        end
        sb_exp.push_back(v.exp);
        sb_name.push_back(v.name);
        @(posedge clock);
        #1;
        got = v.dut ? {if_b.q, if_b.rise, if_b.fall, if_b.busy}
                    : {if_a.q, if_a.rise, if_a.fall, if_a.busy};
        exp = sb_exp.pop_front();
        nm  = sb_name.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got q/rise/fall/busy=%b want %b", nm, idx, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        clear_a = 1'b1;
        clear_b = 1'b1;
        if_a.d  = 1'b0;
        if_b.d  = 1'b0;

        // Held clear with d=1: everything stays 0.
        for (int i = 0; i < 3; i++) add(0, "reset_hold", 1, 1, 4'b0000);
        // Release with d=1: busy after edges 2-4, rise after edge 5.
        add(0, "release", 0, 1, 4'b0000);
        add(0, "release", 0, 1, 4'b0000);
        add(0, "release", 0, 1, 4'b0001);
        add(0, "release", 0, 1, 4'b0001);
        add(0, "release", 0, 1, 4'b0001);
        add(0, "release", 0, 1, 4'b1100);
        add(0, "release", 0, 1, 4'b1000);
        // Clear while HIGH: q drops with no fall pulse, then re-qualifies.
        add(0, "clear_high", 1, 1, 4'b0000);
        add(0, "rerise", 0, 1, 4'b0000);
        add(0, "rerise", 0, 1, 4'b0000);
        add(0, "rerise", 0, 1, 4'b0001);
        add(0, "rerise", 0, 1, 4'b0001);
        add(0, "rerise", 0, 1, 4'b0001);
        add(0, "rerise", 0, 1, 4'b1100);
        add(0, "rerise", 0, 1, 4'b1000);
        // Bounce on release: d toggles every 2 cycles, final fall before edge 8.
        add(0, "bounce", 0, 0, 4'b1000);
        add(0, "bounce", 0, 0, 4'b1000);
        add(0, "bounce", 0, 1, 4'b1001);
        add(0, "bounce", 0, 1, 4'b1001);
        add(0, "bounce", 0, 0, 4'b1000);
        add(0, "bounce", 0, 0, 4'b1000);
        add(0, "bounce", 0, 1, 4'b1001);
        add(0, "bounce", 0, 1, 4'b1001);
        add(0, "bounce", 0, 0, 4'b1000);
        add(0, "bounce", 0, 0, 4'b1000);
        add(0, "bounce", 0, 0, 4'b1001);
        add(0, "bounce", 0, 0, 4'b1001);
        add(0, "bounce", 0, 0, 4'b1001);
        add(0, "bounce", 0, 0, 4'b0010);
        add(0, "bounce", 0, 0, 4'b0000);
        // Glitch of N-1 cycles: aborted on the edge that would have completed it.
        add(0, "glitch", 0, 1, 4'b0000);
        add(0, "glitch", 0, 1, 4'b0000);
        add(0, "glitch", 0, 1, 4'b0001);
        add(0, "glitch", 0, 0, 4'b0001);
        add(0, "glitch", 0, 0, 4'b0001);
        add(0, "glitch", 0, 0, 4'b0000);
        add(0, "glitch", 0, 0, 4'b0000);
        add(0, "glitch", 0, 0, 4'b0000);
        // Pulse of exactly N cycles: accepted, then released.
        add(0, "min_pulse", 0, 1, 4'b0000);
        add(0, "min_pulse", 0, 1, 4'b0000);
        add(0, "min_pulse", 0, 1, 4'b0001);
        add(0, "min_pulse", 0, 1, 4'b0001);
        add(0, "min_pulse", 0, 0, 4'b0001);
        add(0, "min_pulse", 0, 0, 4'b1100);
        add(0, "min_pulse", 0, 0, 4'b1001);
        add(0, "min_pulse", 0, 0, 4'b1001);
        add(0, "min_pulse", 0, 0, 4'b1001);
        add(0, "min_pulse", 0, 0, 4'b0010);
        add(0, "min_pulse", 0, 0, 4'b0000);

        repeat (2) @(posedge clock);
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Hand-written: SYNC_STAGES=3, N=1, d high for exactly one period.
        begin
            vec_t v;
            v.dut = 1;
            v.name = "n1_clear";  v.clr = 1; v.d = 0; v.exp = 4'b0000; run_vec(v, 0);
            v.name = "n1_pulse";  v.clr = 0; v.d = 1; v.exp = 4'b0000; run_vec(v, 1);
            v.name = "n1_pulse";  v.clr = 0; v.d = 0; v.exp = 4'b0000; run_vec(v, 2);
            v.name = "n1_pulse";  v.clr = 0; v.d = 0; v.exp = 4'b0000; run_vec(v, 3);
            v.name = "n1_rise";   v.clr = 0; v.d = 0; v.exp = 4'b1100; run_vec(v, 4);
            v.name = "n1_fall";   v.clr = 0; v.d = 0; v.exp = 4'b0010; run_vec(v, 5);
            v.name = "n1_idle";   v.clr = 0; v.d = 0; v.exp = 4'b0000; run_vec(v, 6);
        end

        // Hand-written: clear mid-WAIT discards the partial count.
        begin
            vec_t v;
            v.dut = 0;
            v.clr = 0; v.d = 1; v.name = "clr_wait";
            v.exp = 4'b0000; run_vec(v, 0);
            v.exp = 4'b0000; run_vec(v, 1);
            v.exp = 4'b0001; run_vec(v, 2);
            v.exp = 4'b0001; run_vec(v, 3);
            v.clr = 1; v.exp = 4'b0000; run_vec(v, 4);
            v.clr = 0;
            v.exp = 4'b0000; run_vec(v, 5);
            v.exp = 4'b0000; run_vec(v, 6);
            v.exp = 4'b0001; run_vec(v, 7);
            v.exp = 4'b0001; run_vec(v, 8);
            v.exp = 4'b0001; run_vec(v, 9);
            v.exp = 4'b1100; run_vec(v, 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Input conditioner that takes a raw asynchronous level (push-button, external request line, bouncing contact) and delivers a clean, synchronous, debounced level plus one-cycle edge pulses. It sits directly upstream of the registered flop stages and drives their data and clear inputs with a signal that is metastability-safe and free of bounce. A multi-flop synchronizer feeds a four-state debounce FSM with a consecutive-sample counter.

## Interface
- SYNC_STAGES, 2: synchronizer depth; legal range 2..4.
- DEBOUNCE_CYCLES, 4: consecutive agreeing samples required to change `q`; legal range 1..255.
- CNT_W, 8: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- clock  in  1  rising-edge clock; the block's only clock.
- clear  in  1  synchronous, active-high reset.
- d      in  1  raw asynchronous input level.
- q      out 1  debounced level, registered.
- rise   out 1  one-cycle pulse on the cycle `q` first reads 1.
- fall   out 1  one-cycle pulse on the cycle `q` first reads 0.
- busy   out 1  high while the FSM is qualifying a candidate transition.

## Operation
- Synchronizer: chain `s[0..SYNC_STAGES-1]`, with `s[0]` <= `d`. The synchronized sample `ds` = `s[SYNC_STAGES-1]`. Only `ds` feeds the FSM.
- Let N = DEBOUNCE_CYCLES.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. `q` = 1 in HIGH and WAIT_LOW. `busy` = 1 in WAIT_HIGH and WAIT_LOW. `cnt` counts consecutive edges at which `ds` != `q`.
- LOW:
  - `ds`=1 and N=1: go to HIGH, pulse `rise`.
  - `ds`=1 and N>1: go to WAIT_HIGH with `cnt`=1.
  - Otherwise stay.
- WAIT_HIGH:
  - `ds`=0: abort to LOW with `cnt`=0. No pulse.
  - `ds`=1 and `cnt`+1=N: go to HIGH, `cnt`=0, pulse `rise`.
  - Otherwise `cnt`++.
- HIGH and WAIT_LOW mirror LOW and WAIT_HIGH with `ds` inverted. The completing transition pulses `fall`.
- `cnt` never exceeds N-1. No wrap-around is possible.
- `rise` and `fall` are registered, high for exactly one cycle, and never high together.
- Clear has priority over all other activity. On an edge with `clear`=1:
  - all `s[]` = 0; state = LOW; `cnt` = 0;
  - `q` = 0, `rise` = 0, `fall` = 0, `busy` = 0.
- Clear mid-WAIT discards the partial count.
- Clear while HIGH drops `q` to 0 without a `fall` pulse.
- With `clear` held, all outputs stay 0 regardless of `d`.

## Timing
- All outputs are registered. Reset value of `q`, `rise`, `fall` and `busy` is 0.
- Latency: `d` changes and is stable before edge 0. `q` changes, and the matching pulse is asserted, after edge SYNC_STAGES+N-1. That is SYNC_STAGES+N edges inclusive: 6 with defaults.
- Defaults, `d` rising before edge 0:
  - `ds`=1 after edge 1.
  - `busy`=1 after edges 2, 3, 4.
  - `q`=1 and `rise`=1 after edge 5.
  - `rise`=0 after edge 6.
- Minimum accepted pulse width on `d` is N clock periods. Shorter excursions are rejected, and `busy` falls on the abort edge.
- A `ds` disagreement on the very edge where `cnt`+1 would reach N aborts the transition. The aborting sample wins.
- After `clear` deasserts, the first edge with `clear`=0 samples `d`. The latency rule applies from that edge.

## Test plan
- Reset: hold `clear`=1 for 3 cycles with `d`=1 -> `q`/`rise`/`fall`/`busy` = 0 throughout. Release -> `rise` after the 6th edge following release, and `q`=1 thereafter.
- Clean rise, defaults: `d` 0->1 before edge 0 -> `busy` high for 3 cycles (after edges 2-4), `q`=1 and `rise`=1 after edge 5, `rise`=0 after edge 6.
- Glitch reject: `d`=1 for 3 cycles then 0 -> `q` stays 0, `rise` never asserts, `busy` high then back to 0.
- Bounce on release: `q`=1, then `d` toggles every 2 cycles for 10 cycles and settles at 0 -> exactly one `fall` pulse, 6 edges after the final `d` fall, and `q`=0 thereafter.
- Clear while HIGH: `q`=1, `d`=1, `clear` pulsed for 1 cycle -> `q`=0 on that edge with `fall`=0. `rise` reasserts 6 edges after release.
- Parameters SYNC_STAGES=3, N=1: `d` high for exactly one period -> `q` and `rise` high after edge 3, then `q`=0 and `fall`=1 after edge 4.
